// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle for mem_bus_arbiter.
// Carries the fetch port (i_*), the data port (d_*) and the shared memory
// port (m_*), plus the sticky error flags.
//   slave  : arbiter view. It consumes requests and memory responses, and
//            drives the completion data and memory commands.
//   master : environment view (pipeline stages plus memory model).
interface mem_bus_arbiter_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  // fetch side
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_valid;
  logic          i_stall;
  // data side
  logic          d_req;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          d_stall;
  // memory side
  logic          m_req;
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ready_n;
  logic          m_busy;
  // status
  logic          err;
  logic          err_src;

  modport slave (
    input  i_req, i_addr, d_req, d_write, d_addr, d_wdata,
           m_rdata, m_ready_n, m_busy,
    output i_rdata, i_valid, i_stall, d_rdata, d_valid, d_stall,
           m_req, m_write, m_addr, m_wdata, err, err_src
  );

  modport master (
    output i_req, i_addr, d_req, d_write, d_addr, d_wdata,
           m_rdata, m_ready_n, m_busy,
    input  i_rdata, i_valid, i_stall, d_rdata, d_valid, d_stall,
           m_req, m_write, m_addr, m_wdata, err, err_src
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between a fetch requester (I) and
// a data requester (D).
// D normally wins. I is forced through after STARVE_MAX consecutive D grants
// while it waits. Each access runs IDLE -> ACC -> DONE -> IDLE. An access
// that gets no m_ready_n within TIMEOUT cycles is aborted with zero data and
// sets the sticky err flag.
// Ports:
//   clk : rising-edge clock.
//   rst : asynchronous, active-low reset.
//   bus : slave modport of mem_bus_arbiter_if.
//         i_*   : fetch port.
//         d_*   : data port.
//         m_*   : memory port.
//         err, err_src : sticky timeout status.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT    = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.slave  bus
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 8;
  localparam int unsigned SW = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;

  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] STARVE_HI = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC, DONE} state_e;

  // latched command of the granted requester
  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_cmd_t;

  state_e        state_q,   state_d;
  logic [TW-1:0] to_cnt_q,  to_cnt_d;
  logic [SW-1:0] starve_q,  starve_d;
  logic          m_req_q,   m_req_d;
  acc_cmd_t      cmd_q,     cmd_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          i_valid_q, i_valid_d;
  logic          d_valid_q, d_valid_d;
  logic          err_q,     err_d;
  logic          err_src_q, err_src_d;

  logic          grant_c;
  logic          i_win_c;

  // arbitration decision, only acted on in IDLE
  always_comb begin
    grant_c = ~bus.m_busy & (bus.i_req | bus.d_req);
    i_win_c = bus.i_req & (~bus.d_req | (starve_q == STARVE_HI));
  end

  // next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    starve_d  = starve_q;
    m_req_d   = m_req_q;
    cmd_d     = cmd_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_valid_d = 1'b0;
    d_valid_d = 1'b0;
    err_d     = err_q;
    err_src_d = err_src_q;

    case (state_q)
      IDLE: begin
        if (grant_c) begin
          to_cnt_d = '0;
          m_req_d  = 1'b1;
          if (i_win_c) begin
            state_d     = I_ACC;
            starve_d    = '0;
            cmd_d.write = 1'b0;
            cmd_d.addr  = bus.i_addr;
          end else begin
            state_d     = D_ACC;
            cmd_d.write = bus.d_write;
            cmd_d.addr  = bus.d_addr;
            cmd_d.wdata = bus.d_wdata;
            // starvation only accrues while fetch is actually waiting
            if (!bus.i_req)
              starve_d = '0;
            else if (starve_q != STARVE_HI)
              starve_d = starve_q + SW'(1);
          end
        end
      end

      I_ACC, D_ACC: begin
        if (!bus.m_ready_n) begin
          state_d     = DONE;
          m_req_d     = 1'b0;
          cmd_d.write = 1'b0;
          if (state_q == I_ACC) begin
            i_rdata_d = bus.m_rdata;
            i_valid_d = 1'b1;
          end else begin
            if (!cmd_q.write)
              d_rdata_d = bus.m_rdata;
            d_valid_d = 1'b1;
          end
        end else if (to_cnt_q == TO_LAST) begin
          // abort: complete with zero data and flag the source
          state_d     = DONE;
          m_req_d     = 1'b0;
          cmd_d.write = 1'b0;
          err_d       = 1'b1;
          if (state_q == I_ACC) begin
            i_rdata_d = '0;
            i_valid_d = 1'b1;
            err_src_d = 1'b0;
          end else begin
            if (!cmd_q.write)
              d_rdata_d = '0;
            d_valid_d = 1'b1;
            err_src_d = 1'b1;
          end
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      to_cnt_q  <= '0;
      starve_q  <= '0;
      m_req_q   <= 1'b0;
      cmd_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      err_q     <= 1'b0;
      err_src_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      starve_q  <= starve_d;
      m_req_q   <= m_req_d;
      cmd_q     <= cmd_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_valid_q <= i_valid_d;
      d_valid_q <= d_valid_d;
      err_q     <= err_d;
      err_src_q <= err_src_d;
    end
  end

  // output drive; stalls follow the live request
  assign bus.m_req   = m_req_q;
  assign bus.m_write = cmd_q.write;
  assign bus.m_addr  = cmd_q.addr;
  assign bus.m_wdata = cmd_q.wdata;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.i_valid = i_valid_q;
  assign bus.d_valid = d_valid_q;
  assign bus.err     = err_q;
  assign bus.err_src = err_src_q;
  assign bus.i_stall = bus.i_req & ~i_valid_q;
  assign bus.d_stall = bus.d_req & ~d_valid_q;

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: cycles an access may wait for m_ready_n before abort (range 2..255).
REQ-002 SHALL have parameter STARVE_MAX, default 4: consecutive D grants tolerated while i_req pending.
REQ-003 SHALL have ports:
 clk  in  1  sole clock, rising edge.
 rst  in  1  asynchronous, active-low reset.
 i_req  in  1  fetch request, held until served.
 i_addr  in  32  fetch address.
 i_rdata  out  32  fetch data.
 i_valid  out  1  one-cycle fetch-complete pulse.
 i_stall  out  1  hold IF stage.
 d_req  in  1  data request, held until served.
 d_write  in  1  1 = store, 0 = load.
 d_addr  in  32  data address.
 d_wdata  in  32  store data.
 d_rdata  out  32  load data.
 d_valid  out  1  one-cycle data-complete pulse.
 d_stall  out  1  hold MEM stage (drives keep).
 m_req  out  1  memory request.
 m_write  out  1  memory write enable.
 m_addr  out  32  memory address.
 m_wdata  out  32  memory write data.
 m_rdata  in  32  memory read data.
 m_ready_n  in  1  active-low completion from memory.
 m_busy  in  1  memory cannot accept a new request.
 err  out  1  sticky timeout flag.
 err_src  out  1  source of last timeout, 0 = I, 1 = D.

Function
REQ-004 SHALL implement FSM states IDLE, I_ACC, D_ACC, DONE.
REQ-005 IDLE: m_busy=1 or no request -> stay; else grant per REQ-006 and latch address/write/wdata of winner into registers at that edge.
REQ-006 Priority: D over I, except when starve count = STARVE_MAX and i_req=1 -> I wins.
REQ-007 Starve count (3-bit min): +1 on D grant while i_req=1; cleared on any I grant or when i_req=0 at a grant; saturates at STARVE_MAX.
REQ-008 I_ACC/D_ACC: m_req=1; m_addr/m_write/m_wdata from latched registers, stable for whole access; m_write=0 in I_ACC.
REQ-009 In ACC, m_ready_n=0 sampled -> DONE; load/fetch captures m_rdata into d_rdata/i_rdata at that edge.
REQ-010 Stores SHALL leave d_rdata unchanged.
REQ-011 DONE lasts exactly one cycle: matching valid=1, m_req=0, no new grant, then IDLE.
REQ-012 Minimum latency: request sampled at edge N, m_ready_n low in cycle N+1 -> valid high in cycle N+2, IDLE in N+3.
REQ-013 Timeout counter clears on grant, increments each ACC cycle; on reaching TIMEOUT-1 with m_ready_n=1 -> DONE, rdata forced to 0, err=1, err_src set.
REQ-014 err remains 1 until reset; further timeouts update err_src only.
REQ-015 i_stall = i_req & ~i_valid; d_stall = d_req & ~d_valid (combinational).
REQ-016 m_ready_n low outside ACC states SHALL be ignored.
REQ-017 m_busy is examined only in IDLE; it does not abort an access in progress.
REQ-018 Requester dropping its req mid-access does not abort; access completes, valid still pulses.

Reset
REQ-019 rst=0 SHALL immediately force IDLE and m_req=0, m_write=0, i_valid=0, d_valid=0, err=0, err_src=0.
REQ-020 rst=0 SHALL clear i_rdata, d_rdata, m_addr, m_wdata, timeout and starve counters to 0.
REQ-021 Reset mid-access SHALL abandon the access with no valid pulse; first grant possible at the first edge after rst=1.

Verification
REQ-022 Load d_addr=0x100, m_ready_n low 1 cycle after m_req, m_rdata=0xDEADBEEF -> d_valid in cycle N+2, d_rdata=0xDEADBEEF, d_stall low same cycle.
REQ-023 i_req and d_req together with 6 back-to-back D requests, STARVE_MAX=4 -> grant order D,D,D,D,I,D,D.
REQ-024 Store d_addr=0x200 d_wdata=0x12345678 -> m_write=1, m_addr/m_wdata stable until m_ready_n; d_rdata unchanged.
REQ-025 m_ready_n held high, TIMEOUT=64 -> m_req high 64 cycles, d_valid pulses with d_rdata=0, err=1, err_src=1, err persists through next access.
REQ-026 m_busy=1 for 5 cycles with i_req=1 -> no m_req; grant on first edge m_busy=0; rst pulsed low during I_ACC -> m_req low immediately, no i_valid.
